// File: rtl/feedthru_pipe_if.sv
// Multi-channel valid/ready bundle carried between feedthru_pipe and its neighbours.
// Lane c of in_data/out_data occupies bits [c*WIDTH +: WIDTH].
interface feedthru_pipe_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) ();
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/feedthru_pipe.sv
// Per-channel feedthrough that is either a combinational bypass or a STAGES-deep
// elastic register pipeline; mode switches wait for the pipeline to empty.
module feedthru_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst,
    feedthru_pipe_if.slave      bus,
    input  logic [CHANNELS-1:0] bypass_req,
    output logic [CHANNELS-1:0] mode_bypass,
    output logic [CHANNELS-1:0] busy
);

    typedef enum logic [1:0] {
        ST_PIPE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_BYPASS = 2'd2
    } state_t;

    logic [CHANNELS-1:0]       in_ready_w;
    logic [CHANNELS-1:0]       out_valid_w;
    logic [CHANNELS*WIDTH-1:0] out_data_w;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t            state;
        logic [STAGES-1:0] vld_p;
        logic [WIDTH-1:0]  data_p [STAGES];
        logic [STAGES-1:0] rdy;
        logic [STAGES-1:0] vld_nxt;
        logic              push;
        logic              empty_nxt;
        logic [WIDTH-1:0]  lane_in;

        assign lane_in = bus.in_data[c*WIDTH +: WIDTH];

        // Ready ripples back from the output so a full pipe still moves every cycle.
        always_comb begin
            rdy = '0;
            rdy[STAGES-1] = !vld_p[STAGES-1] || bus.out_ready[c];
            for (int k = STAGES - 2; k >= 0; k--) begin
                rdy[k] = !vld_p[k] || rdy[k+1];
            end
        end

        assign push = (state == ST_PIPE) && bus.in_valid[c] && rdy[0];

        always_comb begin
            vld_nxt = vld_p;
            if (state == ST_BYPASS) begin
                vld_nxt = '0;
            end else begin
                if (rdy[0]) vld_nxt[0] = push;
                for (int k = 1; k < STAGES; k++) begin
                    if (rdy[k]) vld_nxt[k] = vld_p[k-1];
                end
            end
        end

        // Emptiness after this edge, so a beat leaving or entering now is accounted for.
        assign empty_nxt = ~|vld_nxt;

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_PIPE;
                vld_p <= '0;
                for (int k = 0; k < STAGES; k++) data_p[k] <= '0;
            end else begin
                vld_p <= vld_nxt;
                if (push) data_p[0] <= lane_in;
                for (int k = 1; k < STAGES; k++) begin
                    if (rdy[k] && vld_p[k-1]) data_p[k] <= data_p[k-1];
                end
                case (state)
                    ST_PIPE: begin
                        if (bypass_req[c]) state <= empty_nxt ? ST_BYPASS : ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (!bypass_req[c])  state <= ST_PIPE;
                        else if (empty_nxt)  state <= ST_BYPASS;
                    end
                    ST_BYPASS: begin
                        if (!bypass_req[c]) state <= ST_PIPE;
                    end
                    default: state <= ST_PIPE;
                endcase
            end
        end

        // Nothing transfers on either side while reset is asserted.
        assign in_ready_w[c]  = !rst && ((state == ST_BYPASS) ? bus.out_ready[c]
                                                             : (state == ST_PIPE) && rdy[0]);
        assign out_valid_w[c] = !rst && ((state == ST_BYPASS) ? bus.in_valid[c]
                                                             : vld_p[STAGES-1]);
        assign out_data_w[c*WIDTH +: WIDTH] = (state == ST_BYPASS) ? lane_in : data_p[STAGES-1];
        assign mode_bypass[c] = (state == ST_BYPASS);
        assign busy[c]        = |vld_p;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_data_w;

endmodule

// File: tb/tb_feedthru_pipe.sv
// Directed, table-driven bench for feedthru_pipe (WIDTH=8, CHANNELS=4, STAGES=2).
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_feedthru_pipe;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int STAGES   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] bypass_req;
    logic [3:0] mode_bypass;
    logic [3:0] busy;

    feedthru_pipe_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    feedthru_pipe #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .STAGES(STAGES)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .bypass_req  (bypass_req),
        .mode_bypass (mode_bypass),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [3:0]  iv;
        logic [31:0] id;
        logic [3:0]  ordy;
        logic [3:0]  breq;
        logic [3:0]  e_ir;
        logic [3:0]  e_ov;
        logic [31:0] e_od;
        logic [3:0]  e_mb;
        logic [3:0]  e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] iv, input logic [31:0] id,
                         input logic [3:0] ordy, input logic [3:0] breq);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bypass_req    = breq;
    endtask

    function automatic vec_t mk(input string n, input logic [3:0] iv, input logic [31:0] id,
                                input logic [3:0] ordy, input logic [3:0] breq,
                                input logic [3:0] e_ir, input logic [3:0] e_ov,
                                input logic [31:0] e_od, input logic [3:0] e_mb,
                                input logic [3:0] e_busy);
        vec_t r;
        r.name = n; r.iv = iv; r.id = id; r.ordy = ordy; r.breq = breq;
        r.e_ir = e_ir; r.e_ov = e_ov; r.e_od = e_od; r.e_mb = e_mb; r.e_busy = e_busy;
        return r;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] ov);
        logic [31:0] m;
        m = '0;
        for (int c = 0; c < CHANNELS; c++) if (ov[c]) m[c*WIDTH +: WIDTH] = 8'hFF;
        return m;
    endfunction

    initial begin
        logic [31:0] m;

        //       name    iv     id            ordy  breq  e_ir  e_ov  e_od          e_mb  e_busy
        // ch0 latency: 11,22,33 back to back
        vecs.push_back(mk("lat0", 4'h1, 32'h00000011, 4'hF, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0));
        vecs.push_back(mk("lat1", 4'h1, 32'h00000022, 4'hF, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h1));
        vecs.push_back(mk("lat2", 4'h1, 32'h00000033, 4'hF, 4'h0, 4'hF, 4'h1, 32'h00000011, 4'h0, 4'h1));
        vecs.push_back(mk("lat3", 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h1, 32'h00000022, 4'h0, 4'h1));
        vecs.push_back(mk("lat4", 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h1, 32'h00000033, 4'h0, 4'h1));
        vecs.push_back(mk("lat5", 4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0));
        // ch0 backpressure: third beat refused until out_ready returns
        vecs.push_back(mk("bp0",  4'h1, 32'h00000044, 4'hE, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0));
        vecs.push_back(mk("bp1",  4'h1, 32'h00000055, 4'hE, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h1));
        vecs.push_back(mk("bp2",  4'h1, 32'h00000066, 4'hE, 4'h0, 4'hE, 4'h1, 32'h00000044, 4'h0, 4'h1));
        vecs.push_back(mk("bp3",  4'h1, 32'h00000066, 4'hF, 4'h0, 4'hF, 4'h1, 32'h00000044, 4'h0, 4'h1));
        vecs.push_back(mk("bp4",  4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h1, 32'h00000055, 4'h0, 4'h1));
        vecs.push_back(mk("bp5",  4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h1, 32'h00000066, 4'h0, 4'h1));
        vecs.push_back(mk("bp6",  4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0));
        // ch1 drain then bypass
        vecs.push_back(mk("dr0",  4'h2, 32'h00007100, 4'hD, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0));
        vecs.push_back(mk("dr1",  4'h2, 32'h00007200, 4'hD, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h2));
        vecs.push_back(mk("dr2",  4'h0, 32'h0,        4'hD, 4'h2, 4'hD, 4'h2, 32'h00007100, 4'h0, 4'h2));
        vecs.push_back(mk("dr3",  4'h2, 32'h00009900, 4'hD, 4'h2, 4'hD, 4'h2, 32'h00007100, 4'h0, 4'h2));
        vecs.push_back(mk("dr4",  4'h2, 32'h00009900, 4'hF, 4'h2, 4'hD, 4'h2, 32'h00007100, 4'h0, 4'h2));
        vecs.push_back(mk("dr5",  4'h2, 32'h00009900, 4'hF, 4'h2, 4'hD, 4'h2, 32'h00007200, 4'h0, 4'h2));
        vecs.push_back(mk("dr6",  4'h2, 32'h0000A500, 4'hF, 4'h2, 4'hF, 4'h2, 32'h0000A500, 4'h2, 4'h0));
        vecs.push_back(mk("dr7",  4'h0, 32'h0,        4'hD, 4'h2, 4'hD, 4'h0, 32'h0,        4'h2, 4'h0));
        vecs.push_back(mk("dr8",  4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 32'h0,        4'h2, 4'h0));
        vecs.push_back(mk("dr9",  4'h0, 32'h0,        4'hF, 4'h0, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0));
        // ch0 bypass alongside ch2 pipe
        vecs.push_back(mk("mx0",  4'h0, 32'h0,        4'hF, 4'h1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0));
        vecs.push_back(mk("mx1",  4'h5, 32'h00D100C1, 4'hF, 4'h1, 4'hF, 4'h1, 32'h000000C1, 4'h1, 4'h0));
        vecs.push_back(mk("mx2",  4'h5, 32'h00D200C2, 4'hF, 4'h1, 4'hF, 4'h1, 32'h000000C2, 4'h1, 4'h4));
        vecs.push_back(mk("mx3",  4'h5, 32'h00D300C3, 4'hF, 4'h1, 4'hF, 4'h5, 32'h00D100C3, 4'h1, 4'h4));
        vecs.push_back(mk("mx4",  4'h0, 32'h0,        4'hF, 4'h1, 4'hF, 4'h4, 32'h00D20000, 4'h1, 4'h4));
        vecs.push_back(mk("mx5",  4'h0, 32'h0,        4'hF, 4'h1, 4'hF, 4'h4, 32'h00D30000, 4'h1, 4'h4));
        vecs.push_back(mk("mx6",  4'h0, 32'h0,        4'hF, 4'h1, 4'hF, 4'h0, 32'h0,        4'h1, 4'h0));

        // Reset with random inputs for two edges
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(4'($urandom), $urandom, 4'($urandom), 4'($urandom));
            @(posedge clk); #1;
        end
        rst = 1'b0;
        drive(4'h0, 32'h0, 4'hF, 4'h0);
        @(negedge clk);
        chk("rst.out_valid",   32'(bus.out_valid),   32'h0);
        chk("rst.busy",        32'(busy),            32'h0);
        chk("rst.mode_bypass", 32'(mode_bypass),     32'h0);
        chk("rst.in_ready",    32'(bus.in_ready),    32'hF);
        chk("rst.out_data",    bus.out_data,         32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].breq);
            @(negedge clk);
            m = lane_mask(vecs[i].e_ov);
            chk($sformatf("%s.in_ready", vecs[i].name),    32'(bus.in_ready),  32'(vecs[i].e_ir));
            chk($sformatf("%s.out_valid", vecs[i].name),   32'(bus.out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("%s.out_data", vecs[i].name),    bus.out_data & m,   vecs[i].e_od & m);
            chk($sformatf("%s.mode_bypass", vecs[i].name), 32'(mode_bypass),   32'(vecs[i].e_mb));
            chk($sformatf("%s.busy", vecs[i].name),        32'(busy),          32'(vecs[i].e_busy));
            @(posedge clk); #1;
        end

        // Reset while ch3 is draining two beats (ch0 still held in bypass)
        drive(4'h8, 32'hE1000000, 4'h7, 4'h1);
        @(posedge clk); #1;
        drive(4'h8, 32'hE2000000, 4'h7, 4'h1);
        @(posedge clk); #1;
        drive(4'h0, 32'h0, 4'h7, 4'h9);
        @(negedge clk);
        chk("rmd.full.in_ready", 32'(bus.in_ready), 32'h7);
        chk("rmd.full.busy",     32'(busy),         32'h8);
        @(posedge clk); #1;
        drive(4'h0, 32'h0, 4'hF, 4'h9);
        @(negedge clk);
        chk("rmd.drain.mode_bypass", 32'(mode_bypass), 32'h1);
        chk("rmd.drain.in_ready3",   32'(bus.in_ready[3]), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rmd.rstcyc.out_valid", 32'(bus.out_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(4'h0, 32'h0, 4'hF, 4'h0);
        @(negedge clk);
        chk("rmd.post.busy",        32'(busy),         32'h0);
        chk("rmd.post.mode_bypass", 32'(mode_bypass),  32'h0);
        chk("rmd.post.in_ready",    32'(bus.in_ready), 32'hF);
        chk("rmd.post.out_data",    bus.out_data,      32'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rmd.stale%0d.out_valid", i), 32'(bus.out_valid), 32'h0);
            chk($sformatf("rmd.stale%0d.busy", i),      32'(busy),          32'h0);
            @(posedge clk); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/feedthru_pipe.md
# feedthru_pipe

Parametrised multi-channel feedthrough with per-channel selectable retiming. Each channel carries a valid/ready stream. A channel either passes its stream straight through combinationally (bypass, equivalent to a plain `out = in` feedthrough) or through a STAGES-deep elastic register pipeline. Mode changes are requested at runtime and take effect only once the channel's pipeline is empty, so no beat is lost or reordered. The block sits between hierarchical modules wherever a boundary feedthrough must optionally be retimed.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 4, independent channels
- STAGES, 2, register stages per channel in pipe mode; legal range 1..8

- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  CHANNELS  upstream valid, bit c = channel c
- in_ready  out  CHANNELS  upstream ready
- in_data  in  CHANNELS*WIDTH  lane c = bits [c*WIDTH +: WIDTH]
- out_valid  out  CHANNELS  downstream valid
- out_ready  in  CHANNELS  downstream ready
- out_data  out  CHANNELS*WIDTH  same lane packing as in_data
- bypass_req  in  CHANNELS  1 = request bypass mode, 0 = request pipe mode; level-sensitive
- mode_bypass  out  CHANNELS  1 = channel currently in BYPASS state
- busy  out  CHANNELS  1 = at least one pipeline stage of the channel holds a valid beat

## Operation
- Transfer on a port occurs in a cycle where valid && ready are both high at the clock edge. Channels are fully independent; there is no cross-channel coupling.
- Per-channel FSM with three states, PIPE, DRAIN and BYPASS. Reset state is PIPE for every channel, regardless of bypass_req.
- PIPE:
  - Pipe datapath is active.
  - bypass_req=1 with pipeline empty -> BYPASS.
  - bypass_req=1 with pipeline non-empty -> DRAIN.
- DRAIN:
  - in_ready=0; the pipeline keeps emitting to out_* under out_ready.
  - Pipeline becomes empty (including by a final output transfer this cycle) with bypass_req=1 -> BYPASS.
  - bypass_req=0 -> PIPE. This has priority over the empty transition.
- BYPASS:
  - out_valid=in_valid, out_data=in_data, in_ready=out_ready, all combinational.
  - Stage registers are held empty.
  - bypass_req=0 -> PIPE. Any transfer in the same cycle completes as a bypass transfer.
- Pipe datapath:
  - Stage 0 takes in_data; stage STAGES-1 drives out_data/out_valid.
  - Stage k is ready when it is empty or stage k+1 (or the output, for the last stage) accepts this cycle. This ready chain is combinational, which gives full throughput.
  - in_ready = stage-0 ready (PIPE state only).
  - A stalled stage holds its data unchanged; beats never overwrite, drop or duplicate.
- In PIPE and DRAIN, out_data is the last-stage register even when out_valid=0. The value is don't-care, but it must not carry X after reset: registers reset to 0.
- busy = OR of stage valids. mode_bypass = (state == BYPASS).

## Timing
- Reset (rst high at an edge):
  - All stage valids and data become 0 and the FSM goes to PIPE.
  - After the edge: out_valid=0, out_data=0, busy=0, mode_bypass=0.
  - in_ready=1 in PIPE with an empty pipe.
  - Reset mid-stream discards in-flight beats; no output transfer occurs in the reset cycle.
- Pipe latency: a beat accepted at edge t is presented with out_valid=1 after edge t+STAGES-1, and can transfer at edge t+STAGES, when there is no stall.
- Throughput in pipe mode is 1 beat/cycle with out_ready held high. Capacity per channel is STAGES beats.
- Bypass latency is 0 cycles and purely combinational: no in->out register.
- Mode change:
  - PIPE->BYPASS with an empty pipe takes effect one edge after bypass_req is sampled high.
  - DRAIN lasts until the last beat leaves, then BYPASS is entered at the next edge.
  - BYPASS->PIPE takes effect at the next edge.
- Simultaneous input and output transfer on a full pipeline is legal and keeps occupancy constant.

## Test plan
- Reset: assert rst for 2 cycles with random inputs.
  - Required: out_valid=0, busy=0, mode_bypass=0 and in_ready=all-ones for every channel.
- Latency: STAGES=2, ch0 sends 0x11,0x22,0x33 back-to-back with out_ready=1.
  - Required: the same sequence on out ch0 with 2-cycle latency and no bubbles.
- Backpressure: out_ready=0 while sending 3 beats on STAGES=2.
  - Required: 2 beats are accepted, then in_ready=0.
  - Required: on release, beats arrive in order with no loss or duplication.
- Drain-then-bypass: pipe holding 2 beats, out_ready=0, then raise bypass_req[1].
  - Required: in_ready[1]=0 and mode_bypass[1]=0 until both beats drain after out_ready goes high; mode_bypass[1]=1 the next cycle.
  - Required: afterwards in_data lane 1 = 0xA5 appears on out_data in the same cycle.
- Mixed channels: ch0 in bypass, ch2 in pipe, both streaming.
  - Required: ch0 has zero latency and ch2 has STAGES latency, with no interference between them.
- Reset mid-drain: rst during DRAIN with beats in flight.
  - Required: busy=0 and PIPE state next cycle.
  - Required: no stale beat is emitted afterwards.
